// File: rtl/ram2p1r1wbe_init.sv
// ram2p1r1wbe_init: 1R1W byte-enable RAM with registered rdout, optional forwarding and a clear sequencer; ports clk/reset, clear, ren/raddr/rdout, wen/waddr/wdin/bwe, busy
module ram2p1r1wbe_init #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 44,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit FORWARD = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = (WIDTH-1)/8+1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdout,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdin,
  input  logic [NB-1:0]    bwe,
  output logic             busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, wa;
  logic [WIDTH-1:0] rdout_q, rdout_d, mask, merged, wword;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic we;
  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign mask[i] = bwe[i/8];
  end
  assign merged = (mem_q[waddr] & ~mask) | (wdin & mask);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdout_d = rdout_q;
    we = 1'b0;
    wa = waddr;
    wword = merged;
    if (state_q == CLEAR) begin
      we = 1'b1;
      wa = cnt_q;
      wword = INIT_VALUE;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == AW'(DEPTH-1)) ? IDLE : CLEAR;
    end else begin
      we = wen;
      if (ren) rdout_d = (FORWARD && wen && raddr == waddr) ? merged : mem_q[raddr];
      if (clear) begin
        state_d = CLEAR;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q <= '0;
      rdout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdout_q <= rdout_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && we) mem_q[wa] <= wword;
  end
  assign busy = (state_q == CLEAR);
  assign rdout = rdout_q;
endmodule

// File: tb/tb_ram2p1r1wbe_init.sv
// tb_ram2p1r1wbe_init: directed self-checking bench for ram2p1r1wbe_init
module tb_ram2p1r1wbe_init;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic a_reset, a_clear, a_ren, a_wen, a_busy;
  logic [2:0] a_raddr, a_waddr, a_bwe;
  logic [21:0] a_wdin, a_rdout;
  logic b_reset, b_clear, b_ren, b_wen, b_busy, c_busy;
  logic [3:0] b_raddr, b_waddr, b_bwe;
  logic [31:0] b_wdin, b_rdout, c_rdout;
  localparam logic [21:0] AINIT = 22'h3AAAA;
  localparam logic [31:0] BINIT = 32'hCAFE0001;
  ram2p1r1wbe_init #(.DEPTH(8), .WIDTH(22), .INIT_VALUE(AINIT), .CLEAR_ON_RESET(1'b1), .FORWARD(1'b1)) u_a (
    .clk(clk), .reset(a_reset), .clear(a_clear), .ren(a_ren), .raddr(a_raddr), .rdout(a_rdout),
    .wen(a_wen), .waddr(a_waddr), .wdin(a_wdin), .bwe(a_bwe), .busy(a_busy));
  ram2p1r1wbe_init #(.DEPTH(16), .WIDTH(32), .INIT_VALUE(BINIT), .CLEAR_ON_RESET(1'b1), .FORWARD(1'b1)) u_b (
    .clk(clk), .reset(b_reset), .clear(b_clear), .ren(b_ren), .raddr(b_raddr), .rdout(b_rdout),
    .wen(b_wen), .waddr(b_waddr), .wdin(b_wdin), .bwe(b_bwe), .busy(b_busy));
  ram2p1r1wbe_init #(.DEPTH(16), .WIDTH(32), .INIT_VALUE(BINIT), .CLEAR_ON_RESET(1'b0), .FORWARD(1'b0)) u_c (
    .clk(clk), .reset(b_reset), .clear(b_clear), .ren(b_ren), .raddr(b_raddr), .rdout(c_rdout),
    .wen(b_wen), .waddr(b_waddr), .wdin(b_wdin), .bwe(b_bwe), .busy(c_busy));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_wr(input logic [2:0] ad, input logic [21:0] d, input logic [2:0] be);
    a_wen = 1'b1; a_waddr = ad; a_wdin = d; a_bwe = be;
    tick();
    a_wen = 1'b0;
  endtask
  task automatic a_rd(input logic [2:0] ad);
    a_ren = 1'b1; a_raddr = ad;
    tick();
    a_ren = 1'b0;
  endtask
  task automatic b_wr(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    b_wen = 1'b1; b_waddr = ad; b_wdin = d; b_bwe = be;
    tick();
    b_wen = 1'b0;
  endtask
  task automatic b_rd(input logic [3:0] ad);
    b_ren = 1'b1; b_raddr = ad;
    tick();
    b_ren = 1'b0;
  endtask
  task automatic a_wait(output int n);
    n = 0;
    while (a_busy && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic b_wait(output int n);
    n = 0;
    while (b_busy && n < 40) begin
      tick();
      n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int n;
    a_reset = 1'b0; a_clear = 1'b0; a_ren = 1'b0; a_wen = 1'b0;
    a_raddr = '0; a_waddr = '0; a_wdin = '0; a_bwe = '0;
    b_reset = 1'b0; b_clear = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
    b_raddr = '0; b_waddr = '0; b_wdin = '0; b_bwe = '0;
    a_reset = 1'b1;
    tick();
    chk("a_rst_busy", 64'(a_busy), 64'd1);
    chk("a_rst_rdout", 64'(a_rdout), 64'd0);
    tick();
    a_reset = 1'b0;
    a_wait(n);
    chk("a_rst_clear_len", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      a_rd(3'(i));
      chk($sformatf("a_init_rd%0d", i), 64'(a_rdout), 64'(AINIT));
    end
    a_wr(3'd5, 22'h3FFFFF, 3'b111);
    a_wr(3'd5, 22'h000000, 3'b100);
    a_rd(3'd5);
    chk("a_partial_msb", 64'(a_rdout), 64'h00FFFF);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("a_clr_busy", 64'(a_busy), 64'd1);
    a_wen = 1'b1; a_waddr = 3'd2; a_wdin = 22'h55; a_bwe = 3'b111;
    a_ren = 1'b1; a_raddr = 3'd2;
    tick();
    a_wen = 1'b0;
    chk("a_lock_rdout_hold", 64'(a_rdout), 64'h00FFFF);
    a_wait(n);
    a_ren = 1'b0;
    chk("a_lock_clear_len", 64'(n + 1), 64'd8);
    chk("a_lock_rdout_end", 64'(a_rdout), 64'h00FFFF);
    a_rd(3'd2);
    chk("a_lock_addr2", 64'(a_rdout), 64'(AINIT));
    a_clear = 1'b1; a_wen = 1'b1; a_waddr = 3'd1; a_wdin = 22'h7; a_bwe = 3'b111;
    a_ren = 1'b1; a_raddr = 3'd1;
    tick();
    a_clear = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
    chk("a_simul_fwd", 64'(a_rdout), 64'h7);
    chk("a_simul_busy", 64'(a_busy), 64'd1);
    a_wait(n);
    chk("a_simul_clear_len", 64'(n), 64'd8);
    a_rd(3'd1);
    chk("a_simul_addr1", 64'(a_rdout), 64'(AINIT));
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    chk("b_rst_busy", 64'(b_busy), 64'd1);
    chk("c_rst_busy", 64'(c_busy), 64'd0);
    chk("b_rst_rdout", 64'(b_rdout), 64'd0);
    chk("c_rst_rdout", 64'(c_rdout), 64'd0);
    b_wait(n);
    chk("b_rst_clear_len", 64'(n), 64'd16);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    chk("b_req_busy", 64'(b_busy), 64'd1);
    chk("c_req_busy", 64'(c_busy), 64'd1);
    repeat (4) tick();
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    chk("c_mid_abandon", 64'(c_busy), 64'd0);
    b_wait(n);
    chk("b_mid_restart_len", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      b_rd(4'(i));
      chk($sformatf("b_mid_rd%0d", i), 64'(b_rdout), 64'(BINIT));
      if (i < 4) chk($sformatf("c_kept_rd%0d", i), 64'(c_rdout), 64'(BINIT));
    end
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    b_wait(n);
    chk("b_req_clear_len", 64'(n), 64'd16);
    chk("c_req_done", 64'(c_busy), 64'd0);
    b_wr(4'd3, 32'h11223344, 4'hF);
    b_wen = 1'b1; b_waddr = 4'd3; b_wdin = 32'hAABBCCDD; b_bwe = 4'b0101;
    b_ren = 1'b1; b_raddr = 4'd3;
    tick();
    b_wen = 1'b0; b_ren = 1'b0;
    chk("b_fwd_new", 64'(b_rdout), 64'h11BB33DD);
    chk("c_fwd_old", 64'(c_rdout), 64'h11223344);
    tick();
    chk("b_ren0_hold", 64'(b_rdout), 64'h11BB33DD);
    b_rd(4'd3);
    chk("b_merge_stored", 64'(b_rdout), 64'h11BB33DD);
    chk("c_merge_stored", 64'(c_rdout), 64'h11BB33DD);
    b_wen = 1'b1; b_waddr = 4'd4; b_wdin = 32'h12345678; b_bwe = 4'hF;
    b_ren = 1'b1; b_raddr = 4'd3;
    tick();
    b_wen = 1'b0; b_ren = 1'b0;
    chk("b_diff_addr_rd", 64'(b_rdout), 64'h11BB33DD);
    b_rd(4'd4);
    chk("b_diff_addr_wr", 64'(b_rdout), 64'h12345678);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
